bn_channel_sequencer: RTL and testbench



---
 rtl/bn_channel_sequencer_pkg.sv | 23 ++
 rtl/bn_channel_sequencer_param_table.sv | 42 ++++
 rtl/bn_channel_sequencer.sv | 157 +++++++++++++++
 tb/tb_bn_channel_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bn_channel_sequencer_pkg.sv
// Shared definitions for the batch-norm channel sequencer.
// Holds the sequencer state encoding, parameter-table select codes and default widths.
package bn_channel_sequencer_pkg;

  localparam int BN_DATA_W = 16;
  localparam int BN_NUM_CH = 16;
  localparam int BN_CH_W   = 4;
  localparam int BN_LEN_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } seq_state_t;

  localparam logic [1:0] CFG_SEL_GAMMA = 2'd0;
  localparam logic [1:0] CFG_SEL_BETA  = 2'd1;
  localparam logic [1:0] CFG_SEL_MEAN  = 2'd2;
  localparam logic [1:0] CFG_SEL_VAR   = 2'd3;

endpackage

// File: rtl/bn_channel_sequencer_param_table.sv
// Per-channel batch-norm parameter store: NUM_CH x 4 registers, one write port and
// one channel-indexed read port returning all four parameters at once.
module bn_param_table
  import bn_channel_sequencer_pkg::*;
#(
  parameter int DATA_W = BN_DATA_W,
  parameter int NUM_CH = BN_NUM_CH,
  parameter int CH_W   = BN_CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [1:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_gamma,
  output logic [DATA_W-1:0] rd_beta,
  output logic [DATA_W-1:0] rd_mean,
  output logic [DATA_W-1:0] rd_variance
);

  logic [DATA_W-1:0] mem [NUM_CH][4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < 4; s++) begin
          mem[c][s] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_ch][wr_sel] <= wr_data;
    end
  end

  assign rd_gamma    = mem[rd_ch][CFG_SEL_GAMMA];
  assign rd_beta     = mem[rd_ch][CFG_SEL_BETA];
  assign rd_mean     = mem[rd_ch][CFG_SEL_MEAN];
  assign rd_variance = mem[rd_ch][CFG_SEL_VAR];

endmodule

// File: rtl/bn_channel_sequencer.sv
// Sequences a channel-major activation stream through the BN unit, presenting each
// channel's parameters and only switching them once that channel has fully drained.
module bn_channel_sequencer
  import bn_channel_sequencer_pkg::*;
#(
  parameter int DATA_W = BN_DATA_W,
  parameter int NUM_CH = BN_NUM_CH,
  parameter int CH_W   = BN_CH_W,
  parameter int LEN_W  = BN_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr_en,
  input  logic [CH_W-1:0]   cfg_wr_ch,
  input  logic [1:0]        cfg_wr_sel,
  input  logic [DATA_W-1:0] cfg_wr_data,
  input  logic              start,
  input  logic [CH_W:0]     num_ch,
  input  logic [LEN_W-1:0]  elems_per_ch,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] bn_data,
  output logic              bn_valid,
  input  logic              bn_ready,
  output logic [DATA_W-1:0] gamma,
  output logic [DATA_W-1:0] beta,
  output logic [DATA_W-1:0] mean,
  output logic [DATA_W-1:0] variance,
  input  logic [DATA_W-1:0] bn_out_data,
  input  logic              bn_out_valid,
  output logic              bn_out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last
);

  seq_state_t        state, state_next;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W:0]     num_ch_r;
  logic [LEN_W-1:0]  elems_r;
  logic [LEN_W-1:0]  elems_m1;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  returned;
  logic [DATA_W-1:0] tbl_gamma, tbl_beta, tbl_mean, tbl_variance;
  logic              issue_phase, ret_phase;
  logic              issue_fire, ret_fire;
  logic              last_ch, issue_last, drain_done, empty_run;

  // Table writes are locked out for the whole run so a channel's parameters stay coherent.
  bn_param_table #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (cfg_wr_en & ~busy),
    .wr_ch       (cfg_wr_ch),
    .wr_sel      (cfg_wr_sel),
    .wr_data     (cfg_wr_data),
    .rd_ch       (cur_ch),
    .rd_gamma    (tbl_gamma),
    .rd_beta     (tbl_beta),
    .rd_mean     (tbl_mean),
    .rd_variance (tbl_variance)
  );

  assign issue_phase = (state == ST_ISSUE);
  assign ret_phase   = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign busy        = (state == ST_LOAD) || ret_phase;
  assign done        = (state == ST_FIN);

  assign bn_data     = in_data;
  assign bn_valid    = issue_phase & in_valid;
  assign in_ready    = issue_phase & bn_ready;
  assign issue_fire  = bn_valid & bn_ready;

  // Results are only accepted while a channel is in flight; anything else is stale.
  assign out_data     = bn_out_data;
  assign out_valid    = ret_phase & bn_out_valid;
  assign bn_out_ready = ret_phase & out_ready;
  assign ret_fire     = out_valid & out_ready;

  assign elems_m1   = elems_r - LEN_W'(1);
  assign last_ch    = ((CH_W+1)'(cur_ch) + (CH_W+1)'(1)) == num_ch_r;
  assign issue_last = issue_fire && (issued == elems_m1);
  assign drain_done = (returned == elems_r) || (ret_fire && (returned == elems_m1));
  assign empty_run  = (num_ch == '0) || (elems_per_ch == '0);
  assign out_ch     = cur_ch;
  assign out_last   = out_valid && last_ch && (returned == elems_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = empty_run ? ST_FIN : ST_LOAD;
      ST_LOAD:  state_next = ST_ISSUE;
      ST_ISSUE: if (issue_last) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_next = last_ch ? ST_FIN : ST_LOAD;
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Counter clears on a channel switch are placed last so they win over a same-cycle return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch   <= '0;
      num_ch_r <= '0;
      elems_r  <= '0;
      issued   <= '0;
      returned <= '0;
      gamma    <= '0;
      beta     <= '0;
      mean     <= '0;
      variance <= '0;
    end else begin
      if (state == ST_LOAD) begin
        gamma    <= tbl_gamma;
        beta     <= tbl_beta;
        mean     <= tbl_mean;
        variance <= tbl_variance;
      end
      if (issue_fire) begin
        issued <= issued + LEN_W'(1);
      end
      if (ret_fire) begin
        returned <= returned + LEN_W'(1);
      end
      if ((state == ST_IDLE) && start) begin
        num_ch_r <= num_ch;
        elems_r  <= elems_per_ch;
        cur_ch   <= '0;
        issued   <= '0;
        returned <= '0;
      end
      if ((state == ST_DRAIN) && drain_done && !last_ch) begin
        cur_ch   <= cur_ch + CH_W'(1);
        issued   <= '0;
        returned <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bn_channel_sequencer.sv
// Randomized scoreboard bench for bn_channel_sequencer with a behavioural BN unit
// that applies whatever parameters the sequencer presents when an element is issued.
module tb_bn_channel_sequencer;
  import bn_channel_sequencer_pkg::*;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 16;
  localparam int CH_W   = 4;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_wr_en = 1'b0;
  logic [CH_W-1:0]   cfg_wr_ch = '0;
  logic [1:0]        cfg_wr_sel = '0;
  logic [DATA_W-1:0] cfg_wr_data = '0;
  logic              start = 1'b0;
  logic [CH_W:0]     num_ch = '0;
  logic [LEN_W-1:0]  elems_per_ch = '0;
  logic              busy, done;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] bn_data;
  logic              bn_valid;
  logic              bn_ready = 1'b0;
  logic [DATA_W-1:0] gamma, beta, mean, variance;
  logic [DATA_W-1:0] bn_out_data = '0;
  logic              bn_out_valid = 1'b0;
  logic              bn_out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CH_W-1:0]   out_ch;
  logic              out_last;

  bn_channel_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_ch(cfg_wr_ch), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_data(cfg_wr_data),
    .start(start), .num_ch(num_ch), .elems_per_ch(elems_per_ch), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bn_data(bn_data), .bn_valid(bn_valid), .bn_ready(bn_ready),
    .gamma(gamma), .beta(beta), .mean(mean), .variance(variance),
    .bn_out_data(bn_out_data), .bn_out_valid(bn_out_valid), .bn_out_ready(bn_out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
    logic              last;
  } exp_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    int                due;
  } bn_item_t;

  exp_t              sb[$];
  bn_item_t          bnq[$];
  logic [DATA_W-1:0] ref_tab [NUM_CH][4];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int run_ch = 0, run_elems = 0, run_issued = 0, run_k = 0, run_c = 0;
  int in_pct = 0, bn_pct = 0, out_pct = 0;
  bit traffic_en = 1'b0;
  bit hold_out = 1'b0;
  int bn_valid_cycles = 0, out_count = 0, done_count = 0;
  int last_out_cycle = -10, done_cycle = -10;
  int base_done = 0, base_out = 0, base_bnv = 0;
  exp_t exp_pop;

  always @(posedge clk) cycle <= cycle + 1;

  // Stand-in BN transform; the xor keeps variance observable in every result.
  function automatic logic [DATA_W-1:0] bn_fn(input logic [DATA_W-1:0] x, g, b, m, v);
    logic [DATA_W-1:0] t;
    t = x - m;
    t = g * t;
    return (t + b) ^ v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cycle);
    end
  endtask

  // Upstream source, BN unit model and downstream sink; also pushes expectations on input acceptance.
  always @(negedge clk) begin
    if (traffic_en) begin
      in_valid  = ($urandom_range(99) < in_pct);
      in_data   = DATA_W'($urandom);
      bn_ready  = (bnq.size() < 4) && ($urandom_range(99) < bn_pct);
      out_ready = !hold_out && ($urandom_range(99) < out_pct);
    end else begin
      in_valid  = 1'b0;
      bn_ready  = 1'b0;
      out_ready = 1'b0;
    end
    if (bnq.size() > 0 && bnq[0].due <= cycle) begin
      bn_out_valid = 1'b1;
      bn_out_data  = bnq[0].data;
    end else begin
      bn_out_valid = 1'b0;
      bn_out_data  = '0;
    end
    #1;
    if (bn_valid) bn_valid_cycles++;
    if (in_valid && in_ready) begin
      run_k = run_issued;
      run_c = run_k / run_elems;
      sb.push_back('{data: bn_fn(in_data, ref_tab[run_c][0], ref_tab[run_c][1],
                                 ref_tab[run_c][2], ref_tab[run_c][3]),
                     ch:   CH_W'(run_c),
                     last: (run_k == run_ch * run_elems - 1)});
      run_issued++;
    end
    if (bn_valid && bn_ready)
      bnq.push_back('{data: bn_fn(bn_data, gamma, beta, mean, variance),
                      due:  cycle + 1 + int'($urandom_range(3))});
    if (bn_out_valid && bn_out_ready) void'(bnq.pop_front());
  end

  // Monitor: compares every accepted downstream output against the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (done) begin
      done_count++;
      done_cycle = cycle;
      checkOutput("busy_low_with_done", {31'd0, busy}, 32'd0);
    end
    if (out_valid && out_ready) begin
      out_count++;
      if (out_last) last_out_cycle = cycle;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output actual=%0h required=none", out_data);
      end else begin
        exp_pop = sb.pop_front();
        checkOutput("out_data", {16'd0, out_data}, {16'd0, exp_pop.data});
        checkOutput("out_ch", {28'd0, out_ch}, {28'd0, exp_pop.ch});
        checkOutput("out_last", {31'd0, out_last}, {31'd0, exp_pop.last});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic cfgWrite(input int ch, input logic [1:0] sel, input logic [DATA_W-1:0] d, input bit taken);
    step();
    cfg_wr_en   = 1'b1;
    cfg_wr_ch   = CH_W'(ch);
    cfg_wr_sel  = sel;
    cfg_wr_data = d;
    if (taken) ref_tab[ch][sel] = d;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    checkOutput({tag, "_bn_valid"}, {31'd0, bn_valid}, 32'd0);
    checkOutput({tag, "_params"}, {gamma, beta} | {mean, variance}, 32'd0);
    checkOutput({tag, "_out_ch"}, {28'd0, out_ch}, 32'd0);
  endtask

  task automatic beginRun(input int nc, input int ne);
    bit empty;
    empty = (nc == 0) || (ne == 0);
    base_done = done_count;
    base_out  = out_count;
    base_bnv  = bn_valid_cycles;
    step();
    start        = 1'b1;
    num_ch       = (CH_W+1)'(nc);
    elems_per_ch = LEN_W'(ne);
    run_ch       = nc;
    run_elems    = ne;
    run_issued   = 0;
    step();
    start = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, {31'd0, !empty});
    checkOutput("done_after_start", {31'd0, done}, {31'd0, empty});
  endtask

  task automatic finishRun(input int budget);
    int waited;
    waited = 0;
    while (!done && waited < budget) begin
      step();
      waited++;
    end
    checkOutput("done_seen", {31'd0, done}, 32'd1);
    if (run_ch * run_elems > 0)
      checkOutput("done_after_last_return", done_cycle, last_out_cycle + 1);
    step();
    checkOutput("done_single_pulse", {31'd0, done}, 32'd0);
    checkOutput("done_count", done_count - base_done, 1);
    checkOutput("output_count", out_count - base_out, run_ch * run_elems);
    checkOutput("scoreboard_empty", sb.size(), 0);
    if (run_ch * run_elems == 0)
      checkOutput("no_bn_valid", bn_valid_cycles - base_bnv, 0);
  endtask

  task automatic waitIssued(input int n, input int budget);
    int waited;
    waited = 0;
    while (run_issued < n && waited < budget) begin
      step();
      waited++;
    end
    checkOutput("issued_reached", run_issued, n);
  endtask

  task automatic applyStimulus(input int nc, input int ne, input int ip, input int bp, input int op);
    in_pct = ip;
    bn_pct = bp;
    out_pct = op;
    traffic_en = 1'b1;
    beginRun(nc, ne);
    finishRun(4000);
  endtask

  task automatic doReset();
    step();
    rst_n = 1'b0;
    #1;
    checkResetValues("reset");
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    traffic_en = 1'b0;
    hold_out = 1'b0;
    sb.delete();
    bnq.delete();
    run_issued = 0;
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < 4; s++)
        ref_tab[c][s] = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < 4; s++)
        ref_tab[c][s] = '0;
    step();
    checkResetValues("por");
    step();
    rst_n = 1'b1;

    $display("[TB] two-channel directed run");
    cfgWrite(0, CFG_SEL_GAMMA, 16'd2, 1'b1);
    cfgWrite(0, CFG_SEL_BETA,  16'd1, 1'b1);
    cfgWrite(0, CFG_SEL_MEAN,  16'd0, 1'b1);
    cfgWrite(0, CFG_SEL_VAR,   16'd0, 1'b1);
    cfgWrite(1, CFG_SEL_GAMMA, 16'd1, 1'b1);
    cfgWrite(1, CFG_SEL_BETA,  16'd0, 1'b1);
    cfgWrite(1, CFG_SEL_MEAN,  16'd4, 1'b1);
    cfgWrite(1, CFG_SEL_VAR,   16'd0, 1'b1);
    applyStimulus(2, 3, 100, 100, 100);
    applyStimulus(2, 3, 60, 70, 60);

    $display("[TB] downstream stall in drain");
    in_pct = 100; bn_pct = 100; out_pct = 100;
    hold_out = 1'b1;
    traffic_en = 1'b1;
    beginRun(2, 3);
    waitIssued(3, 200);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("stall_gamma_held", {16'd0, gamma}, {16'd0, ref_tab[0][0]});
      checkOutput("stall_no_issue", {31'd0, bn_valid}, 32'd0);
    end
    hold_out = 1'b0;
    finishRun(4000);

    $display("[TB] empty runs");
    applyStimulus(0, 3, 100, 100, 100);
    applyStimulus(2, 0, 100, 100, 100);

    $display("[TB] config write and restart while busy");
    in_pct = 50; bn_pct = 50; out_pct = 50;
    beginRun(2, 4);
    cfgWrite(1, CFG_SEL_GAMMA, 16'd99, 1'b0);
    start = 1'b1;
    num_ch = 5'd1;
    elems_per_ch = 16'd1;
    step();
    start = 1'b0;
    finishRun(4000);
    applyStimulus(2, 2, 80, 80, 80);

    $display("[TB] random 16 x 5 run");
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < 4; s++)
        cfgWrite(c, 2'(s), DATA_W'($urandom), 1'b1);
    applyStimulus(16, 5, 55, 50, 60);

    $display("[TB] reset in the middle of issue");
    in_pct = 70; bn_pct = 70; out_pct = 70;
    traffic_en = 1'b1;
    beginRun(4, 6);
    waitIssued(3, 200);
    doReset();
    cfgWrite(0, CFG_SEL_GAMMA, DATA_W'($urandom), 1'b1);
    cfgWrite(0, CFG_SEL_MEAN,  DATA_W'($urandom), 1'b1);
    applyStimulus(2, 2, 70, 70, 70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
